// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } tx_feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with combinational head output; flush clears pointers and count.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       Tx_rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem[rd_ptr_q];

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;

  always_ff @(posedge clk or posedge Tx_rst) begin
    if (Tx_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and start-pulse sequencer in front of the UART transmitter.
// Optional UART_TX_LEVEL_EN exposes the FIFO occupancy on the level port.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int IDLE_GAP = 0
) (
  input  logic              clk,
  input  logic              Tx_rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              flush,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy
`ifdef UART_TX_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]     count;
  logic              full, empty;
  logic [DATA_W-1:0] head;
  logic              pop;

  tx_feed_state_t    state_q, state_d;
  logic [7:0]        gap_q, gap_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk    (clk),
    .Tx_rst (Tx_rst),
    .push   (wr_valid),
    .pop    (pop),
    .flush  (flush),
    .din    (wr_data),
    .dout   (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign pop = (state_q == IDLE) && !empty && !flush;

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (IDLE_GAP != 0) begin
            state_d = GAP;
            gap_d   = 8'(IDLE_GAP);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Tx_rst) begin
    if (Tx_rst) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign wr_ready = !full;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != IDLE) || (count != '0);

`ifdef UART_TX_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: one instance without gap, one with IDLE_GAP=3.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       wr_valid = 1'b0, flush = 1'b0, tx_done = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, tx_start, busy;
  logic [7:0] tx_data;

  logic       b_wr_valid = 1'b0, b_flush = 1'b0, b_tx_done = 1'b0;
  logic [7:0] b_wr_data = 8'h00;
  logic       b_wr_ready, b_tx_start, b_busy;
  logic [7:0] b_tx_data;

`ifdef UART_TX_LEVEL_EN
  logic [2:0] level, b_level;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(4), .IDLE_GAP(0)) dut (
    .clk      (clk),
    .Tx_rst   (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .flush    (flush),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy)
`ifdef UART_TX_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  uart_tx_feeder #(.DEPTH(4), .IDLE_GAP(3)) dut_gap (
    .clk      (clk),
    .Tx_rst   (rst),
    .wr_valid (b_wr_valid),
    .wr_data  (b_wr_data),
    .wr_ready (b_wr_ready),
    .flush    (b_flush),
    .tx_start (b_tx_start),
    .tx_data  (b_tx_data),
    .tx_done  (b_tx_done),
    .busy     (b_busy)
`ifdef UART_TX_LEVEL_EN
    ,
    .level    (b_level)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int lv_exp [5] = '{1, 1, 2, 3, 4};

    // reset state
    step();
    step();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    rst = 1'b0;
    step();

    // single byte: start one cycle after the push edge, busy drops after done
    wr_valid = 1'b1; wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    chk("single_start_early", 32'(tx_start), 32'd0);
    chk("single_busy",        32'(busy),     32'd1);
    step();
    chk("single_start",       32'(tx_start), 32'd1);
    chk("single_data",        32'(tx_data),  32'hA5);
    step();
    chk("single_start_pulse", 32'(tx_start), 32'd0);
    chk("single_data_hold",   32'(tx_data),  32'hA5);
    repeat (97) step();
    chk("single_busy_wait",   32'(busy),     32'd1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("single_busy_fall",   32'(busy),     32'd0);

    // burst of five into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      step();
      chk($sformatf("burst_ready_%0d", i), 32'(wr_ready), (i < 5) ? 32'd1 : 32'd0);
      chk($sformatf("burst_start_%0d", i), 32'(tx_start), (i == 2) ? 32'd1 : 32'd0);
`ifdef UART_TX_LEVEL_EN
      chk($sformatf("burst_level_%0d", i), 32'(level), 32'(lv_exp[i-1]));
`endif
    end
    wr_valid = 1'b0;
    chk("burst_first_data", 32'(tx_data), 32'h01);
    step();
    chk("burst_no_restart", 32'(tx_start), 32'd0);
    for (int j = 2; j <= 5; j++) begin
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      chk($sformatf("burst_ready_pre_%0d", j), 32'(wr_ready), (j == 2) ? 32'd0 : 32'd1);
      step();
      chk($sformatf("burst_order_start_%0d", j), 32'(tx_start), 32'd1);
      chk($sformatf("burst_order_data_%0d", j),  32'(tx_data),  32'(j));
      chk($sformatf("burst_ready_post_%0d", j),  32'(wr_ready), 32'd1);
`ifdef UART_TX_LEVEL_EN
      chk($sformatf("burst_level_pop_%0d", j), 32'(level), 32'(5 - j));
`endif
      step();
      chk($sformatf("burst_pulse_%0d", j), 32'(tx_start), 32'd0);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("burst_idle_busy", 32'(busy), 32'd0);

    // tx_done while idle must not trigger anything
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    chk("stray_done_start", 32'(tx_start), 32'd0);
    chk("stray_done_busy",  32'(busy),     32'd0);

    // flush during WAIT: current byte kept, queued bytes and the same-cycle push dropped
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'h11 * 8'(i + 1);
      step();
    end
    wr_valid = 1'b0;
    step();
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h44;
    step();
    flush = 1'b0; wr_valid = 1'b0;
    chk("flush_data_kept", 32'(tx_data),  32'h11);
    chk("flush_busy_wait", 32'(busy),     32'd1);
    chk("flush_ready",     32'(wr_ready), 32'd1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("flush_busy_after", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("flush_no_start_%0d", k), 32'(tx_start), 32'd0);
    end

    // idle gap of 3: next start lands four cycles after the done edge
    b_wr_valid = 1'b1; b_wr_data = 8'hC1;
    step();
    b_wr_data = 8'hC2;
    step();
    b_wr_valid = 1'b0;
    chk("gap_first_start", 32'(b_tx_start), 32'd1);
    chk("gap_first_data",  32'(b_tx_data),  32'hC1);
    step();
    step();
    b_tx_done = 1'b1;
    step();
    b_tx_done = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("gap_start_%0d", k), 32'(b_tx_start), (k == 4) ? 32'd1 : 32'd0);
    end
    chk("gap_second_data", 32'(b_tx_data), 32'hC2);

    // asynchronous reset mid-frame with two bytes queued
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = 8'hD1 + 8'(i);
      step();
    end
    wr_valid = 1'b0;
    chk("mid_pre_data", 32'(tx_data), 32'hD1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_data",  32'(tx_data),  32'h00);
    chk("mid_rst_ready", 32'(wr_ready), 32'd1);
    chk("mid_rst_busy",  32'(busy),     32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mid_no_start_%0d", k), 32'(tx_start), 32'd0);
    end
    chk("mid_idle_busy", 32'(busy), 32'd0);
    wr_valid = 1'b1; wr_data = 8'hE7;
    step();
    wr_valid = 1'b0;
    step();
    chk("mid_new_start", 32'(tx_start), 32'd1);
    chk("mid_new_data",  32'(tx_data),  32'hE7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
